tc_drain: RTL and testbench
===========================

# tc_drain

Result drain stage directly downstream of the tensor-core datapath. Accepts a complete M×N accumulated result matrix as one wide parallel word, buffers it, and streams it out row-major as LANES elements per beat over a valid/ready interface. Decouples the single-shot wide result from a narrow memory/writeback port, with an optional compiled-in ReLU on the output lanes.

## Interface
- `M`, 32, result rows; ≥1
- `N`, 32, result columns; must be a multiple of `LANES`
- `DW_OUT`, 32, element width, signed two's complement
- `LANES`, 4, elements per output beat
- `clk`  input  1  clock, all state on rising edge
- `reset`  input  1  asynchronous, active-low reset (0 = reset asserted)
- `flush`  input  1  synchronous abort; returns to IDLE
- `in_valid`  input  1  `in_data` holds a complete result matrix
- `in_data`  input  M*N*DW_OUT  element (r,c) at bits [(r*N+c)*DW_OUT +: DW_OUT]
- `in_ready`  output  1  high only in IDLE
- `m_valid`  output  1  output beat valid
- `m_ready`  input  1  downstream accepts beat
- `m_data`  output  LANES*DW_OUT  lane l = element (m_row, m_col+l) at [l*DW_OUT +: DW_OUT]
- `m_row`  output  max(1,$clog2(M))  row of current beat
- `m_col`  output  max(1,$clog2(N))  column of lane 0
- `m_last`  output  1  high with final beat (m_row=M-1, m_col=N-LANES)
- `busy`  output  1  high in DRAIN

## Operation
- States: IDLE, DRAIN.
- IDLE: `in_ready`=1, `m_valid`=0. On `in_valid` & `in_ready`: capture full `in_data` into internal buffer, row/col pointers ← 0, go DRAIN.
- DRAIN: `in_ready`=0, `m_valid`=1; `m_data` driven from buffer at (row, col..col+LANES-1); `in_valid` ignored.
- Handshake (`m_valid` & `m_ready`): col ← col+LANES; if col = N-LANES then col ← 0, row ← row+1. If beat is last → IDLE.
- Beats per matrix: M*N/LANES (256 at defaults).
- `m_valid`, `m_data`, `m_row`, `m_col`, `m_last` held stable while `m_valid` & !`m_ready`.
- `flush`=1: next state IDLE, pointers ← 0, buffer contents undefined-but-unused; `flush` takes priority over capture and over an output handshake in the same cycle.
- No capture on the cycle the last beat completes: `in_ready` rises the cycle after the last handshake.
- Buffer contents not cleared by reset; only pointers/state reset.

## Timing
- Reset (`reset`=0, asynchronous): state IDLE, row=col=0; outputs: `in_ready`=1, `m_valid`=0, `m_last`=0, `busy`=0, `m_row`=0, `m_col`=0, `m_data` don't-care (lanes undriven by reset).
- Reset deasserted mid-DRAIN: stream aborted, no further beats.
- Capture edge T: `m_valid`=1 from T+1, first beat (0,0) on `m_data` at T+1.
- With `m_ready` held high: one beat per cycle, last beat at T+M*N/LANES, `in_ready`=1 at T+M*N/LANES+1. Minimum matrix-to-matrix interval M*N/LANES+1 cycles.
- `m_data` is a mux of buffer by registered pointers: combinational from state, no input-to-output combinational path from `m_ready` or `in_valid`.

## Configuration
- `TC_DRAIN_RELU_EN` defined: each lane whose MSB is 1 outputs all-zeros; non-negative lanes pass unchanged. Applied on output path only; buffer holds raw values.
- Undefined: lanes pass raw signed values; no ReLU logic instantiated.

## Test plan
- Reset/idle: hold `reset`=0 then release, `in_valid`=0 → `in_ready`=1, `m_valid`=0, `busy`=0 indefinitely.
- Full drain, defaults, element(r,c)=r*256+c, `m_ready`=1 → 256 beats, beat k has m_row=k/8, m_col=(k%8)*4, lane l = m_row*256+m_col+l, `m_last` only on beat 255, `in_ready`=1 next cycle.
- Backpressure: toggle `m_ready` 1-0-0-1 pseudo-random → no beat lost/duplicated, outputs stable during stalls, ordering identical to full drain.
- Flush: `flush`=1 at beat 37 with `m_ready`=1 → beat 37 not counted, IDLE next cycle, new matrix then drains from (0,0).
- Async reset mid-DRAIN at beat 100 → `m_valid`=0 immediately, `in_ready`=1 after release, no residual beats.
- `TC_DRAIN_RELU_EN`: elements alternating -5 and 7 → with macro lanes read 0,7,0,7; without macro -5,7,-5,7.

Source files
------------

// File: rtl/tc_drain.sv
// Result drain: captures a full MxN result matrix and streams it row-major, LANES elements per beat.
// Optional output ReLU is compiled in with `define TC_DRAIN_RELU_EN.
module tc_drain #(
   parameter int M      = 32,
   parameter int N      = 32,
   parameter int DW_OUT = 32,
   parameter int LANES  = 4,
   localparam int RW    = (M > 1) ? $clog2(M) : 1,
   localparam int CW    = (N > 1) ? $clog2(N) : 1
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    flush,
   input  logic                    in_valid,
   input  logic [M*N*DW_OUT-1:0]   in_data,
   output logic                    in_ready,
   output logic                    m_valid,
   input  logic                    m_ready,
   output logic [LANES*DW_OUT-1:0] m_data,
   output logic [RW-1:0]           m_row,
   output logic [CW-1:0]           m_col,
   output logic                    m_last,
   output logic                    busy
);
   localparam int EW = (M * N > 1) ? $clog2(M * N) : 1;

   localparam logic [0:0] IDLE  = 1'b0;
   localparam logic [0:0] DRAIN = 1'b1;

   logic [0:0]        state;
   logic [RW-1:0]     row;
   logic [CW-1:0]     col;
   logic [DW_OUT-1:0] mem [M*N];
   logic              col_end;
   logic              last_beat;
   logic [EW-1:0]     base;

   assign col_end   = (col == CW'(N - LANES));
   assign last_beat = col_end && (row == RW'(M - 1));

   assign in_ready = (state == IDLE);
   assign m_valid  = (state == DRAIN);
   assign busy     = (state == DRAIN);
   assign m_last   = (state == DRAIN) && last_beat;
   assign m_row    = row;
   assign m_col    = col;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
         row   <= '0;
         col   <= '0;
      end else if (flush) begin
         state <= IDLE;
         row   <= '0;
         col   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  state <= DRAIN;
                  row   <= '0;
                  col   <= '0;
               end
            end
            DRAIN: begin
               if (m_ready) begin
                  if (last_beat) begin
                     state <= IDLE;
                     row   <= '0;
                     col   <= '0;
                  end else if (col_end) begin
                     col <= '0;
                     row <= row + 1'b1;
                  end else begin
                     col <= col + CW'(LANES);
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Buffer is deliberately unreset; only the pointers say what is live.
   always_ff @(posedge clk) begin
      if (in_valid && in_ready && !flush) begin
         for (int i = 0; i < M * N; i++) mem[i] <= in_data[i*DW_OUT +: DW_OUT];
      end
   end

   assign base = EW'(row) * EW'(N) + EW'(col);

   for (genvar l = 0; l < LANES; l++) begin : g_lane
      logic [DW_OUT-1:0] raw;
      assign raw = mem[base + EW'(l)];
`ifdef TC_DRAIN_RELU_EN
      assign m_data[l*DW_OUT +: DW_OUT] = raw[DW_OUT-1] ? '0 : raw;
`else
      assign m_data[l*DW_OUT +: DW_OUT] = raw;
`endif
   end
endmodule

// File: tb/tb_tc_drain.sv
// Scoreboard bench for tc_drain: expected beats are queued at capture and popped on each handshake.
module tb_tc_drain;
   localparam int M = 32, N = 32, DW = 32, LANES = 4;
   localparam int BEATS = M * N / LANES;
   localparam int RW = 5, CW = 5;

   logic clk = 0, reset = 0, flush = 0, in_valid = 0, m_ready = 0;
   logic [M*N*DW-1:0] in_data = '0;
   logic in_ready, m_valid, m_last, busy;
   logic [LANES*DW-1:0] m_data;
   logic [RW-1:0] m_row;
   logic [CW-1:0] m_col;

   typedef struct {
      logic [LANES*DW-1:0] data;
      int                  row;
      int                  col;
      logic                last;
   } beat_t;

   beat_t       sb[$];
   logic [DW-1:0] mat [M*N];
   int checks = 0, errors = 0;

   tc_drain #(.M(M), .N(N), .DW_OUT(DW), .LANES(LANES)) dut (
      .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_data(in_data),
      .in_ready(in_ready), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
      .m_row(m_row), .m_col(m_col), .m_last(m_last), .busy(busy)
   );

   always #5 clk = ~clk;

   function automatic logic [DW-1:0] relu(input logic [DW-1:0] v);
`ifdef TC_DRAIN_RELU_EN
      return v[DW-1] ? '0 : v;
`else
      return v;
`endif
   endfunction

   task automatic load_matrix(input int pattern);
      int r, c;
      for (int i = 0; i < M * N; i++) begin
         r = i / N;
         c = i % N;
         case (pattern)
            0:       mat[i] = DW'(r * 256 + c);
            1:       mat[i] = (c % 2 == 0) ? 32'hFFFF_FFFB : 32'd7;
            default: mat[i] = $urandom;
         endcase
         in_data[i*DW +: DW] = mat[i];
      end
   endtask

   task automatic push_expected();
      beat_t b;
      sb.delete();
      for (int k = 0; k < BEATS; k++) begin
         b.row  = k / (N / LANES);
         b.col  = (k % (N / LANES)) * LANES;
         b.last = (k == BEATS - 1);
         for (int l = 0; l < LANES; l++) b.data[l*DW +: DW] = relu(mat[b.row*N + b.col + l]);
         sb.push_back(b);
      end
   endtask

   task automatic capture(input int pattern);
      int t;
      load_matrix(pattern);
      t = 0;
      while (!in_ready && t < 100) begin @(posedge clk); #1; t++; end
      checks++;
      if (in_ready !== 1'b1) begin errors++; $display("FAIL capture_ready: in_ready=%0b want 1", in_ready); end
      in_valid = 1;
      @(posedge clk); #1;
      in_valid = 0;
      push_expected();
   endtask

   // mode 0: m_ready held high; mode 1: pseudo-random m_ready
   task automatic drain(input int mode, input int stop_at, output int consumed, output int cycles);
      logic stalled;
      beat_t held, exp;
      consumed = 0; cycles = 0; stalled = 0;
      while (consumed < stop_at && cycles < 5000) begin
         m_ready = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
         checks++;
         if (m_valid !== 1'b1 || busy !== 1'b1 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL drain_flags: valid=%0b busy=%0b in_ready=%0b want 1 1 0", m_valid, busy, in_ready);
         end
         if (stalled) begin
            checks++;
            if (m_data !== held.data || int'(m_row) !== held.row || int'(m_col) !== held.col || m_last !== held.last) begin
               errors++;
               $display("FAIL stall_stable: row=%0d col=%0d last=%0b data=%h want row=%0d col=%0d last=%0b data=%h",
                        m_row, m_col, m_last, m_data, held.row, held.col, held.last, held.data);
            end
         end
         if (m_valid && m_ready) begin
            checks++;
            if (sb.size() == 0) begin
               errors++;
               $display("FAIL extra_beat: row=%0d col=%0d with empty scoreboard", m_row, m_col);
            end else begin
               exp = sb.pop_front();
               if (m_data !== exp.data || int'(m_row) !== exp.row || int'(m_col) !== exp.col || m_last !== exp.last) begin
                  errors++;
                  $display("FAIL beat: row=%0d col=%0d last=%0b data=%h want row=%0d col=%0d last=%0b data=%h",
                           m_row, m_col, m_last, m_data, exp.row, exp.col, exp.last, exp.data);
               end
            end
            consumed++;
            stalled = 0;
         end else begin
            stalled = m_valid;
            held.data = m_data; held.row = int'(m_row); held.col = int'(m_col); held.last = m_last;
         end
         @(posedge clk); #1;
         cycles++;
      end
      checks++;
      if (consumed != stop_at) begin
         errors++;
         $display("FAIL drain_timeout: consumed=%0d want %0d", consumed, stop_at);
      end
   endtask

   task automatic check_idle(input string tag);
      checks++;
      if (in_ready !== 1'b1 || m_valid !== 1'b0 || busy !== 1'b0 || m_last !== 1'b0) begin
         errors++;
         $display("FAIL %s: in_ready=%0b valid=%0b busy=%0b last=%0b want 1 0 0 0", tag, in_ready, m_valid, busy, m_last);
      end
   endtask

   task automatic test_reset();
      reset = 0;
      repeat (3) @(posedge clk);
      #1;
      check_idle("reset_idle");
      checks++;
      if (m_row !== '0 || m_col !== '0) begin
         errors++; $display("FAIL reset_ptr: row=%0d col=%0d want 0 0", m_row, m_col);
      end
      reset = 1;
      repeat (10) begin @(posedge clk); #1; check_idle("idle_hold"); end
   endtask

   task automatic test_full_drain();
      int n, cy;
      capture(0);
      drain(0, BEATS, n, cy);
      checks++;
      if (cy != BEATS) begin errors++; $display("FAIL drain_cycles: cycles=%0d want %0d", cy, BEATS); end
      check_idle("after_last");
      checks++;
      if (sb.size() != 0) begin errors++; $display("FAIL sb_left: %0d beats left want 0", sb.size()); end
   endtask

   task automatic test_backpressure();
      int n, cy;
      capture(2);
      drain(1, BEATS, n, cy);
      check_idle("bp_after_last");
   endtask

   task automatic test_back_to_back();
      int n, cy;
      capture(0);
      load_matrix(2);    // new data and in_valid held high while draining: must be ignored
      in_valid = 1;
      drain(0, BEATS, n, cy);
      checks++;
      if (in_ready !== 1'b1 || m_valid !== 1'b0) begin
         errors++; $display("FAIL b2b_gap: in_ready=%0b valid=%0b want 1 0", in_ready, m_valid);
      end
      @(posedge clk); #1;
      in_valid = 0;
      push_expected();
      drain(0, BEATS, n, cy);
      check_idle("b2b_end");
   endtask

   task automatic test_flush();
      int n, cy;
      capture(0);
      drain(0, 37, n, cy);
      m_ready = 1;
      flush = 1;
      @(posedge clk); #1;
      flush = 0;
      check_idle("flush_idle");
      checks++;
      if (m_row !== '0 || m_col !== '0) begin
         errors++; $display("FAIL flush_ptr: row=%0d col=%0d want 0 0", m_row, m_col);
      end
      capture(2);
      drain(0, BEATS, n, cy);
      check_idle("flush_redrain_end");
   endtask

   task automatic test_async_reset();
      int n, cy;
      capture(2);
      drain(0, 100, n, cy);
      #2 reset = 0;
      #1;
      check_idle("async_reset");
      @(posedge clk); #1;
      reset = 1;
      sb.delete();
      m_ready = 1;
      repeat (20) begin @(posedge clk); #1; check_idle("no_residual"); end
   endtask

   task automatic test_relu();
      int n, cy;
      logic [LANES*DW-1:0] exp0;
`ifdef TC_DRAIN_RELU_EN
      exp0 = {32'd7, 32'd0, 32'd7, 32'd0};
`else
      exp0 = {32'd7, 32'hFFFF_FFFB, 32'd7, 32'hFFFF_FFFB};
`endif
      capture(1);
      checks++;
      if (m_data !== exp0) begin errors++; $display("FAIL relu_first: data=%h want %h", m_data, exp0); end
      drain(0, BEATS, n, cy);
   endtask

   initial begin
      test_reset();
      test_full_drain();
      test_backpressure();
      test_back_to_back();
      test_flush();
      test_async_reset();
      test_relu();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
